// File: rtl/pc_fetch_unit.sv
// Sequential instruction-fetch stage: fetches via imem req/ack, hands words to decode via valid/ready,
// and writes PC/LR into the special register file. Define PC_FETCH_BRANCH_LINK_EN to enable the LR write on branch-with-link.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        br_link,
  output logic        wr_pc,
  output logic [31:0] wr_pc_data,
  output logic        wr_lr,
  output logic [31:0] wr_lr_data
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        wr_pc_q, wr_pc_d;
  logic [31:0] wr_pc_data_q, wr_pc_data_d;
  logic [31:0] seq_pc;
  logic [31:0] redirect_pc;

`ifdef PC_FETCH_BRANCH_LINK_EN
  logic        wr_lr_q, wr_lr_d;
  logic [31:0] wr_lr_data_q, wr_lr_data_d;
`else
  logic        unused_br_link;
  assign unused_br_link = br_link;
`endif

  assign seq_pc      = pc_q + PC_INC;
  assign redirect_pc = br_taken ? br_target : pc_q;

  // Every output is computed one cycle ahead so it can be registered; the strobes default low so they only pulse.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    wr_pc_d       = 1'b0;
    wr_pc_data_d  = wr_pc_data_q;
`ifdef PC_FETCH_BRANCH_LINK_EN
    wr_lr_d       = 1'b0;
    wr_lr_data_d  = wr_lr_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALTED;
        end else begin
          state_d     = FETCH;
          imem_req_d  = 1'b1;
          imem_addr_d = pc_q;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          state_d       = HOLD;
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          pc_d          = seq_pc;
          wr_pc_d       = 1'b1;
          wr_pc_data_d  = seq_pc;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
        end
      end
      HOLD: begin
        // Branch inputs matter only on the handshake; a redirect still applies when halting.
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_pc;
          if (br_taken) begin
            wr_pc_d      = 1'b1;
            wr_pc_data_d = br_target;
`ifdef PC_FETCH_BRANCH_LINK_EN
            if (br_link) begin
              wr_lr_d      = 1'b1;
              wr_lr_data_d = instr_pc_q + PC_INC;
            end
`endif
          end
          if (halt) begin
            state_d = HALTED;
          end else begin
            state_d     = FETCH;
            imem_req_d  = 1'b1;
            imem_addr_d = redirect_pc;
          end
        end
      end
      HALTED: begin
        if (!halt) begin
          state_d     = FETCH;
          imem_req_d  = 1'b1;
          imem_addr_d = pc_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      wr_pc_q       <= 1'b0;
      wr_pc_data_q  <= '0;
`ifdef PC_FETCH_BRANCH_LINK_EN
      wr_lr_q       <= 1'b0;
      wr_lr_data_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      wr_pc_q       <= wr_pc_d;
      wr_pc_data_q  <= wr_pc_data_d;
`ifdef PC_FETCH_BRANCH_LINK_EN
      wr_lr_q       <= wr_lr_d;
      wr_lr_data_q  <= wr_lr_data_d;
`endif
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign wr_pc       = wr_pc_q;
  assign wr_pc_data  = wr_pc_data_q;
`ifdef PC_FETCH_BRANCH_LINK_EN
  assign wr_lr       = wr_lr_q;
  assign wr_lr_data  = wr_lr_data_q;
`else
  assign wr_lr       = 1'b0;
  assign wr_lr_data  = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: a default-reset instance plus a second one
// with RESET_PC at the top of the address space to exercise wrap-around.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, halt, imem_ack, instr_ready, br_taken, br_link;
  logic [31:0] imem_rdata, br_target;
  logic        imem_req, instr_valid, wr_pc, wr_lr;
  logic [31:0] imem_addr, instr, instr_pc, wr_pc_data, wr_lr_data;

  logic        reset2, imem_ack2, instr_ready2;
  logic        imem_req2, instr_valid2, wr_pc2, wr_lr2;
  logic [31:0] imem_addr2, instr2, instr_pc2, wr_pc_data2, wr_lr_data2;

  int checks = 0;
  int errors = 0;
  logic [31:0] heldInstr, heldPc;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .br_taken(br_taken), .br_target(br_target), .br_link(br_link),
    .wr_pc(wr_pc), .wr_pc_data(wr_pc_data), .wr_lr(wr_lr), .wr_lr_data(wr_lr_data)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .reset(reset2), .halt(1'b0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(32'h0000_BEEF),
    .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2), .instr_ready(instr_ready2),
    .br_taken(1'b0), .br_target(32'h0), .br_link(1'b0),
    .wr_pc(wr_pc2), .wr_pc_data(wr_pc_data2), .wr_lr(wr_lr2), .wr_lr_data(wr_lr_data2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic hlt, input logic ack, input logic [31:0] rdata,
                               input logic rdy, input logic bt, input logic [31:0] tgt, input logic bl);
    reset       = rst;
    halt        = hlt;
    imem_ack    = ack;
    imem_rdata  = rdata;
    instr_ready = rdy;
    br_taken    = bt;
    br_target   = tgt;
    br_link     = bl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset2 = 1'b1; imem_ack2 = 1'b0; instr_ready2 = 1'b0;
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    step(); step();
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_wrpc", wr_pc, 0);
    checkOutput("rst_wrlr", wr_lr, 0);
    checkOutput("rst_instr", instr, 32'h0);

    // First fetch after reset
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    step();
    checkOutput("f0_req", imem_req, 1);
    checkOutput("f0_addr", imem_addr, 32'h0);
    applyStimulus(0, 0, 1, 32'hA5A5_0001, 0, 0, 32'h0, 0);
    step();
    checkOutput("f0_valid", instr_valid, 1);
    checkOutput("f0_instr", instr, 32'hA5A5_0001);
    checkOutput("f0_ipc", instr_pc, 32'h0);
    checkOutput("f0_wrpc", wr_pc, 1);
    checkOutput("f0_wrpc_data", wr_pc_data, 32'd4);
    checkOutput("f0_req_low", imem_req, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    step();
    checkOutput("f0_wrpc_pulse", wr_pc, 0);
    checkOutput("f0_valid_held", instr_valid, 1);

    // Sequential fetches at 4 and 8; ack held during HOLD must be ignored
    applyStimulus(0, 0, 0, 32'h0, 1, 0, 32'h0, 0);
    step();
    checkOutput("f1_addr", imem_addr, 32'd4);
    checkOutput("f1_req", imem_req, 1);
    checkOutput("f1_valid_low", instr_valid, 0);
    applyStimulus(0, 0, 1, 32'hA5A5_0002, 1, 0, 32'h0, 0);
    step();
    checkOutput("f1_ipc", instr_pc, 32'd4);
    checkOutput("f1_wrpc_data", wr_pc_data, 32'd8);
    step();
    checkOutput("f2_addr", imem_addr, 32'd8);
    checkOutput("f2_req", imem_req, 1);
    checkOutput("f2_nobranch_wrpc", wr_pc, 0);
    step();
    checkOutput("f2_instr", instr, 32'hA5A5_0003 & 32'h0 | 32'hA5A5_0002);
    checkOutput("f2_ipc", instr_pc, 32'd8);
    checkOutput("f2_wrpc_data", wr_pc_data, 32'd12);

    // Taken branch with link at instr_pc=8
    applyStimulus(0, 0, 0, 32'h0, 1, 1, 32'h100, 1);
    step();
    checkOutput("br_wrpc", wr_pc, 1);
    checkOutput("br_wrpc_data", wr_pc_data, 32'h100);
    checkOutput("br_addr", imem_addr, 32'h100);
    checkOutput("br_req", imem_req, 1);
`ifdef PC_FETCH_BRANCH_LINK_EN
    checkOutput("br_wrlr", wr_lr, 1);
    checkOutput("br_wrlr_data", wr_lr_data, 32'd12);
`else
    checkOutput("br_wrlr", wr_lr, 0);
    checkOutput("br_wrlr_data", wr_lr_data, 32'd0);
`endif
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    step();
    checkOutput("br_wrpc_pulse", wr_pc, 0);
    checkOutput("br_wrlr_pulse", wr_lr, 0);
    checkOutput("br_addr_hold", imem_addr, 32'h100);

    // Stall with branch inputs toggling, then halt at handshake
    applyStimulus(0, 0, 1, 32'hA5A5_0004, 0, 0, 32'h0, 0);
    step();
    checkOutput("st_ipc", instr_pc, 32'h100);
    checkOutput("st_wrpc_data", wr_pc_data, 32'h104);
    heldInstr = instr;
    heldPc    = instr_pc;
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 32'h200, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("st_instr", instr, heldInstr);
      checkOutput("st_ipc_stable", instr_pc, heldPc);
      checkOutput("st_req", imem_req, 0);
      checkOutput("st_valid", instr_valid, 1);
      checkOutput("st_wrpc_ign", wr_pc, 0);
    end
    applyStimulus(0, 1, 0, 32'h0, 1, 0, 32'h0, 0);
    step();
    checkOutput("hlt_req", imem_req, 0);
    checkOutput("hlt_valid", instr_valid, 0);
    applyStimulus(0, 1, 1, 32'h0, 0, 0, 32'h0, 0);
    step();
    checkOutput("hlt_req2", imem_req, 0);
    checkOutput("hlt_valid2", instr_valid, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    step();
    checkOutput("resume_req", imem_req, 1);
    checkOutput("resume_addr", imem_addr, 32'h104);

    // Reset while a request is being acked
    applyStimulus(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0, 0);
    step();
    checkOutput("mr_valid", instr_valid, 0);
    checkOutput("mr_wrpc", wr_pc, 0);
    checkOutput("mr_req", imem_req, 0);
    checkOutput("mr_addr", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    step();
    checkOutput("mr_restart_req", imem_req, 1);
    checkOutput("mr_restart_addr", imem_addr, 32'h0);
    checkOutput("mr_valid2", instr_valid, 0);

    // Halt during FETCH does not cancel the pending request
    applyStimulus(0, 1, 1, 32'hA5A5_0005, 0, 0, 32'h0, 0);
    step();
    checkOutput("hf_valid", instr_valid, 1);
    checkOutput("hf_instr", instr, 32'hA5A5_0005);
    applyStimulus(0, 1, 0, 32'h0, 1, 0, 32'h0, 0);
    step();
    checkOutput("hf_halted_req", imem_req, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    step();
    checkOutput("hf_resume_addr", imem_addr, 32'd4);

    // Wrap-around instance
    checkOutput("wr_rst_addr", imem_addr2, 32'hFFFF_FFFC);
    reset2 = 1'b0;
    step();
    checkOutput("wr_req", imem_req2, 1);
    checkOutput("wr_addr", imem_addr2, 32'hFFFF_FFFC);
    imem_ack2 = 1'b1;
    step();
    checkOutput("wr_wrpc_data", wr_pc_data2, 32'h0);
    checkOutput("wr_ipc", instr_pc2, 32'hFFFF_FFFC);
    checkOutput("wr_instr", instr2, 32'h0000_BEEF);
    imem_ack2 = 1'b0;
    instr_ready2 = 1'b1;
    step();
    checkOutput("wr_next_addr", imem_addr2, 32'h0);
    checkOutput("wr_next_req", imem_req2, 1);
    checkOutput("wr_wrlr", wr_lr2, 0);
    checkOutput("wr_lr_data", wr_lr_data2, 32'h0);
    checkOutput("wr_valid", instr_valid2, 0);
    checkOutput("wr_wrpc_pulse", wr_pc2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
